// File: rtl/fu_seq_if.sv
// Operand/result bundle between the control unit (master) and the fu_seq function unit (slave).
// Carries the start/busy/done handshake, the operands and the registered result and flags.
interface fu_seq_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FS_WIDTH   = 4
);
    logic                  start_in;
    logic [DATA_WIDTH-1:0] a_in;
    logic [DATA_WIDTH-1:0] b_in;
    logic [FS_WIDTH-1:0]   fs_in;
    logic                  busy_out;
    logic                  done_out;
    logic [DATA_WIDTH-1:0] f_out;
    logic                  z_out;
    logic                  n_out;
    logic                  c_out;
    logic                  v_out;
    logic                  illegal_out;

    modport master (
        output start_in, a_in, b_in, fs_in,
        input  busy_out, done_out, f_out, z_out, n_out, c_out, v_out, illegal_out
    );

    modport slave (
        input  start_in, a_in, b_in, fs_in,
        output busy_out, done_out, f_out, z_out, n_out, c_out, v_out, illegal_out
    );
endinterface

// File: rtl/fu_seq.sv
// Sequential function unit: single-cycle ALU ops plus an iterative shift-add FMUL.
// Result and Z/N/C/V flags are registered and update only on a done edge.
module fu_seq #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FS_WIDTH   = 4
) (
    input logic      clk,
    input logic      rst,
    fu_seq_if.slave  bus
);
    localparam int unsigned Msb  = DATA_WIDTH - 1;
    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

    localparam logic [FS_WIDTH-1:0] FsMova = FS_WIDTH'(0);
    localparam logic [FS_WIDTH-1:0] FsInc  = FS_WIDTH'(1);
    localparam logic [FS_WIDTH-1:0] FsDec  = FS_WIDTH'(2);
    localparam logic [FS_WIDTH-1:0] FsAdd  = FS_WIDTH'(3);
    localparam logic [FS_WIDTH-1:0] FsSub  = FS_WIDTH'(4);
    localparam logic [FS_WIDTH-1:0] FsClr  = FS_WIDTH'(5);
    localparam logic [FS_WIDTH-1:0] FsAnd  = FS_WIDTH'(6);
    localparam logic [FS_WIDTH-1:0] FsOr   = FS_WIDTH'(7);
    localparam logic [FS_WIDTH-1:0] FsXor  = FS_WIDTH'(8);
    localparam logic [FS_WIDTH-1:0] FsNot  = FS_WIDTH'(9);
    localparam logic [FS_WIDTH-1:0] FsMovb = FS_WIDTH'(10);
    localparam logic [FS_WIDTH-1:0] FsShr  = FS_WIDTH'(11);
    localparam logic [FS_WIDTH-1:0] FsShl  = FS_WIDTH'(12);
    localparam logic [FS_WIDTH-1:0] FsMul  = FS_WIDTH'(13);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e                  state_q;
    logic                    busy_q;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   f_q;
    logic                    z_q;
    logic                    n_q;
    logic                    c_q;
    logic                    v_q;
    logic                    ill_q;
    logic [CntW-1:0]         cnt_q;
    logic [2*DATA_WIDTH-1:0] acc_q;
    logic [2*DATA_WIDTH-1:0] mcand_q;
    logic [DATA_WIDTH-1:0]   mplier_q;

    logic [DATA_WIDTH-1:0]   a;
    logic [DATA_WIDTH-1:0]   b;
    logic [DATA_WIDTH:0]     add_r;
    logic [DATA_WIDTH:0]     sub_r;
    logic [DATA_WIDTH-1:0]   alu_f;
    logic                    alu_c;
    logic                    alu_v;
    logic                    alu_ill;
    logic [2*DATA_WIDTH-1:0] acc_nxt;

    assign a = bus.a_in;
    assign b = bus.b_in;

    // INC/DEC reuse the adder/subtractor with an implicit second operand of 1.
    always_comb begin
        logic [DATA_WIDTH-1:0] rhs;
        rhs = b;
        if (bus.fs_in == FsInc || bus.fs_in == FsDec) begin
            rhs = DATA_WIDTH'(1);
        end
        add_r = {1'b0, a} + {1'b0, rhs};
        sub_r = {1'b0, a} - {1'b0, rhs};

        alu_f   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (bus.fs_in)
            FsMova: alu_f = a;
            FsInc, FsAdd: begin
                alu_f = add_r[Msb:0];
                alu_c = add_r[DATA_WIDTH];
                alu_v = (a[Msb] == rhs[Msb]) && (add_r[Msb] != a[Msb]);
            end
            FsDec, FsSub: begin
                alu_f = sub_r[Msb:0];
                alu_c = sub_r[DATA_WIDTH];
                alu_v = (a[Msb] != rhs[Msb]) && (sub_r[Msb] != a[Msb]);
            end
            FsClr:  alu_f = '0;
            FsAnd:  alu_f = a & b;
            FsOr:   alu_f = a | b;
            FsXor:  alu_f = a ^ b;
            FsNot:  alu_f = ~a;
            FsMovb: alu_f = b;
            FsShr: begin
                alu_f = {1'b0, b[Msb:1]};
                alu_c = b[0];
            end
            FsShl: begin
                alu_f = {b[Msb-1:0], 1'b0};
                alu_c = b[Msb];
            end
            FsMul:  alu_f = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            f_q      <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            ill_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start_in) begin
                        if (bus.fs_in == FsMul) begin
                            mcand_q  <= {{DATA_WIDTH{1'b0}}, a};
                            mplier_q <= b;
                            acc_q    <= '0;
                            cnt_q    <= CntW'(DATA_WIDTH);
                            busy_q   <= 1'b1;
                            state_q  <= StMul;
                        end else begin
                            f_q    <= alu_f;
                            z_q    <= (alu_f == '0);
                            n_q    <= alu_f[Msb];
                            c_q    <= alu_c;
                            v_q    <= alu_v;
                            ill_q  <= alu_ill;
                            done_q <= 1'b1;
                        end
                    end
                end
                StMul: begin
                    acc_q    <= acc_nxt;
                    mcand_q  <= {mcand_q[2*DATA_WIDTH-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[Msb:1]};
                    cnt_q    <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        f_q     <= acc_nxt[Msb:0];
                        z_q     <= (acc_nxt[Msb:0] == '0);
                        n_q     <= acc_nxt[Msb];
                        c_q     <= |acc_nxt[2*DATA_WIDTH-1:DATA_WIDTH];
                        v_q     <= 1'b0;
                        ill_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy_out    = busy_q;
    assign bus.done_out    = done_q;
    assign bus.f_out       = f_q;
    assign bus.z_out       = z_q;
    assign bus.n_out       = n_q;
    assign bus.c_out       = c_q;
    assign bus.v_out       = v_q;
    assign bus.illegal_out = ill_q;
endmodule

// File: tb/tb_fu_seq.sv
// Bench for fu_seq: directed ops, an arithmetic reference model checked every cycle,
// and hand-computed literal checks at each done.
module tb_fu_seq;
    localparam int W = 16;
    localparam longint Mask = (64'd1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fu_seq_if #(.DATA_WIDTH(W), .FS_WIDTH(4)) bus ();

    fu_seq #(.DATA_WIDTH(W), .FS_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit     m_busy, m_done, m_z, m_n, m_c, m_v, m_ill;
    longint m_f;
    int     m_left;
    longint p_f;
    bit     p_c, p_v, p_ill;

    function automatic void model_op(input int fs, input longint a, input longint b,
                                     output longint f, output bit c, output bit v,
                                     output bit ill);
        longint sa, sb, sf, p;
        f = 0; c = 0; v = 0; ill = 0;
        if (fs == 1 || fs == 2) b = 1;
        sa = (a >> (W - 1)) & 1;
        sb = (b >> (W - 1)) & 1;
        case (fs)
            0:  f = a;
            1, 3: begin
                p = a + b;
                f = p & Mask;
                c = (p > Mask);
                sf = (f >> (W - 1)) & 1;
                v = (sa == sb) && (sf != sa);
            end
            2, 4: begin
                f = (a - b) & Mask;
                c = (a < b);
                sf = (f >> (W - 1)) & 1;
                v = (sa != sb) && (sf != sa);
            end
            5:  f = 0;
            6:  f = a & b;
            7:  f = a | b;
            8:  f = a ^ b;
            9:  f = (~a) & Mask;
            10: f = b;
            11: begin f = b >> 1; c = b[0]; end
            12: begin f = (b << 1) & Mask; c = sb[0]; end
            13: begin
                p = a * b;
                f = p & Mask;
                c = ((p >> W) != 0);
            end
            default: ill = 1;
        endcase
    endfunction

    function automatic void apply(input longint f, input bit c, input bit v, input bit ill);
        m_f = f; m_z = (f == 0); m_n = ((f >> (W - 1)) & 1) != 0;
        m_c = c; m_v = v; m_ill = ill; m_done = 1;
    endfunction

    always @(posedge clk) begin
        longint f;
        bit c, v, ill;
        if (rst) begin
            m_busy = 0; m_done = 0; m_f = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;
            m_ill = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    apply(p_f, p_c, p_v, p_ill);
                end
            end else if (bus.start_in) begin
                model_op(int'(bus.fs_in), longint'(bus.a_in), longint'(bus.b_in), f, c, v, ill);
                if (bus.fs_in == 4'd13) begin
                    p_f = f; p_c = c; p_v = v; p_ill = ill;
                    m_busy = 1; m_left = W;
                end else begin
                    apply(f, c, v, ill);
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        vectors++;
        if (bus.busy_out !== m_busy || bus.done_out !== m_done ||
            longint'(bus.f_out) !== m_f || bus.z_out !== m_z || bus.n_out !== m_n ||
            bus.c_out !== m_c || bus.v_out !== m_v || bus.illegal_out !== m_ill) begin
            miscompares++;
            $display("FAIL model t=%0t: got busy%0b done%0b f=%h z%0b n%0b c%0b v%0b ill%0b, want busy%0b done%0b f=%h z%0b n%0b c%0b v%0b ill%0b",
                     $time, bus.busy_out, bus.done_out, bus.f_out, bus.z_out, bus.n_out,
                     bus.c_out, bus.v_out, bus.illegal_out, m_busy, m_done, m_f[W-1:0],
                     m_z, m_n, m_c, m_v, m_ill);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Flags packed as {z,n,c,v,ill}
    function automatic logic [4:0] flags();
        return {bus.z_out, bus.n_out, bus.c_out, bus.v_out, bus.illegal_out};
    endfunction

    // Call at a negedge; returns at the negedge where done_out is seen.
    task automatic op(input logic [3:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int busy_cycles);
        int n;
        bus.start_in = 1'b1; bus.fs_in = fs; bus.a_in = a; bus.b_in = b;
        @(negedge clk);
        bus.start_in = 1'b0;
        busy_cycles = 0;
        n = 0;
        while (!bus.done_out && n < 40) begin
            if (bus.busy_out) busy_cycles++;
            n++;
            @(negedge clk);
        end
        if (!bus.done_out) chk("done timeout", 0, 1);
    endtask

    int bc;

    initial begin
        bus.start_in = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.fs_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset f", longint'(bus.f_out), 0);
        chk("reset flags", longint'({flags(), bus.busy_out, bus.done_out}), 0);

        op(4'd3, 16'h7FFF, 16'h0001, bc);
        chk("add ovf f", longint'(bus.f_out), 'h8000);
        chk("add ovf flags", longint'(flags()), 5'b01010);
        @(negedge clk);
        op(4'd3, 16'hFFFF, 16'h0001, bc);
        chk("add carry f", longint'(bus.f_out), 0);
        chk("add carry flags", longint'(flags()), 5'b10100);

        op(4'd4, 16'h0003, 16'h0005, bc);
        chk("sub f", longint'(bus.f_out), 'hFFFE);
        chk("sub flags", longint'(flags()), 5'b01100);
        op(4'd2, 16'h8000, 16'h0000, bc);
        chk("dec f", longint'(bus.f_out), 'h7FFF);
        chk("dec flags", longint'(flags()), 5'b00010);
        op(4'd9, 16'h00FF, 16'h0000, bc);
        chk("not f", longint'(bus.f_out), 'hFF00);

        // Mid-idle reset
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("idle reset f", longint'(bus.f_out), 0);
        chk("idle reset flags", longint'(flags()), 0);

        @(negedge clk);
        op(4'd13, 16'h0123, 16'h0010, bc);
        chk("mul busy cycles", bc, 16);
        chk("mul f", longint'(bus.f_out), 'h1230);
        chk("mul flags", longint'(flags()), 5'b00000);
        @(negedge clk);

        // FMUL with a start pulse mid-busy that must be ignored
        bus.start_in = 1'b1; bus.fs_in = 4'd13; bus.a_in = 16'h1000; bus.b_in = 16'h0100;
        @(negedge clk);
        bus.start_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.start_in = 1'b1; bus.fs_in = 4'd10; bus.b_in = 16'h5555;
        @(negedge clk);
        bus.start_in = 1'b0;
        begin
            int n = 0;
            while (!bus.done_out && n < 40) begin n++; @(negedge clk); end
            chk("mul2 done seen", longint'(bus.done_out), 1);
        end
        chk("mul2 f", longint'(bus.f_out), 0);
        chk("mul2 flags", longint'(flags()), 5'b10100);
        @(negedge clk);
        chk("mul2 ignored start", longint'(bus.done_out), 0);

        // Back-to-back
        op(4'd1, 16'hFFFF, 16'h0000, bc);
        chk("inc f", longint'(bus.f_out), 0);
        chk("inc flags", longint'(flags()), 5'b10100);
        op(4'd12, 16'h0000, 16'h8001, bc);
        chk("shl f", longint'(bus.f_out), 'h0002);
        chk("shl c", longint'(bus.c_out), 1);
        op(4'd11, 16'h0000, 16'h0001, bc);
        chk("shr f", longint'(bus.f_out), 0);
        chk("shr flags", longint'(flags()), 5'b10100);

        op(4'd14, 16'h1234, 16'h5678, bc);
        chk("rsvd f", longint'(bus.f_out), 0);
        chk("rsvd flags", longint'(flags()), 5'b10001);
        op(4'd6, 16'hF0F0, 16'h0FF0, bc);
        chk("and f", longint'(bus.f_out), 'h00F0);
        chk("and flags", longint'(flags()), 5'b00000);
        @(negedge clk);
        chk("hold f", longint'(bus.f_out), 'h00F0);

        // Reset mid-FMUL at the 5th busy cycle
        bus.start_in = 1'b1; bus.fs_in = 4'd13; bus.a_in = 16'd3; bus.b_in = 16'd5;
        @(negedge clk);
        bus.start_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort busy before rst", longint'(bus.busy_out), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", longint'(bus.busy_out), 0);
        chk("abort done", longint'(bus.done_out), 0);
        chk("abort f", longint'(bus.f_out), 0);
        repeat (20) begin
            @(negedge clk);
            chk("abort no done", longint'(bus.done_out), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fu_seq.md
Name: fu_seq

Overview:
- Parametrised, sequential successor to the CPU function unit; sits in the datapath between the register file read ports and the write-back mux.
- Implements the full fs_t operation set at generic DATA_WIDTH, plus an iterative shift-add multiplier for FMUL.
- Provides registered, complete status flags (Z, N, C, V).
- Uses a start/busy/done handshake so the control unit can stall during multi-cycle operations.

Parameters:
- DATA_WIDTH, 16, operand/result width in bits (>= 4)
- FS_WIDTH, 4, function-select width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start_in  input  1  request; sampled only while idle
- a_in  input  DATA_WIDTH  operand A
- b_in  input  DATA_WIDTH  operand B
- fs_in  input  FS_WIDTH  function select (mycpu_pkg::fs_t encoding)
- busy_out  output  1  high while a multi-cycle operation is in progress
- done_out  output  1  one-cycle pulse when f_out and flags are updated
- f_out  output  DATA_WIDTH  registered result
- z_out  output  1  result == 0
- n_out  output  1  result MSB
- c_out  output  1  carry/borrow/shift-out/mul-overflow
- v_out  output  1  signed overflow
- illegal_out  output  1  last accepted fs was reserved

Behaviour:
- Single clock domain (clk). rst is synchronous and active-high and takes priority over everything.
- Reset state: state=IDLE; busy_out, done_out, f_out, z_out, n_out, c_out, v_out and illegal_out are all 0. The internal counter and accumulator are cleared.
- Reset mid-FMUL aborts the operation. No done_out is produced, and the outputs show reset values on the next cycle.
- fs encoding: 0 MOVA, 1 FINC, 2 FDEC, 3 FADD, 4 FSUB, 5 FCLR, 6 FAND, 7 FOR, 8 FXOR, 9 FNOT, 10 FMOVB, 11 FSHR, 12 FSHL, 13 FMUL; 14–15 reserved.
- States: IDLE and MUL.
- IDLE, start_in=0: no change. All outputs hold, and done_out=0.
- IDLE, start_in=1, non-FMUL op: the result and flags are registered on that edge. done_out=1 in the following cycle (latency 1). State stays IDLE.
- IDLE, start_in=1, FMUL: a_in and b_in are captured, counter=DATA_WIDTH, accumulator=0, and the state moves to MUL. busy_out=1 from the next cycle.
- MUL, each cycle: if the multiplier LSB=1, the accumulator gains the shifted multiplicand. The multiplier shifts right, the multiplicand shifts left (2*DATA_WIDTH wide), and the counter decrements.
- MUL exit: on the edge where counter==1, f_out = product[DATA_WIDTH-1:0] and the state returns to IDLE. busy_out=0 and done_out=1 in that next cycle. Total FMUL latency = DATA_WIDTH+1 cycles after the start cycle (17 at default).
- start_in while busy_out=1 is ignored (no queueing). start_in in the done_out cycle is accepted, so back-to-back operation is supported.
- f_out and the flags change only on a done edge (or reset). They hold between operations.
- Arithmetic wraps modulo 2^DATA_WIDTH.
- Flags for every op: z_out = (f_out==0); n_out = f_out[MSB].
- c_out by op:
  - FADD/FINC: carry out.
  - FSUB/FDEC: borrow (a < b unsigned; a==0 for DEC).
  - FSHR: b[0]; FSHL: b[MSB].
  - FMUL: upper product half != 0.
  - All others: 0.
- v_out by op:
  - FADD/FINC: signed overflow (same-sign operands, different-sign result).
  - FSUB/FDEC: signed overflow (different-sign operands, result sign != a sign).
  - All others: 0.
- Ops:
  - MOVA: f=a. MOVB: f=b. CLR: f=0.
  - INC: a+1. DEC: a-1. ADD: a+b. SUB: a-b.
  - AND/OR/XOR: bitwise. NOT: ~a.
  - SHR: b>>1, logical, zero fill. SHL: b<<1.
- Reserved fs: treated as single-cycle. f=0, z=1, n=c=v=0, illegal_out=1. illegal_out is cleared by the next accepted legal op.

Test Plan:
- Reset: assert rst for 2 cycles mid-idle → all outputs 0. Start FMUL 3×5, assert rst at the 5th busy cycle → busy_out=0 next cycle, no done_out, f_out=0.
- FADD 16'h7FFF + 16'h0001 → done next cycle, f=16'h8000, n=1, v=1, c=0, z=0. FADD 16'hFFFF + 16'h0001 → f=0, z=1, c=1, v=0.
- FSUB 16'h0003 − 16'h0005 → f=16'hFFFE, c=1 (borrow), n=1, v=0. FDEC 16'h8000 → f=16'h7FFF, v=1.
- FMUL 16'h0123 × 16'h0010 → busy_out for 16 cycles, done_out at cycle 17, f=16'h1230, c=0. FMUL 16'h1000 × 16'h0100 → f=0, z=1, c=1. start_in pulsed mid-busy is ignored.
- Back-to-back: FINC 16'hFFFF → f=0, z=1, c=1. FSHL 16'h8001 issued in the done cycle → next done f=16'h0002, c=1. FSHR 16'h0001 → f=0, z=1, c=1.
- Reserved fs=14 → f=0, z=1, illegal_out=1. A following FAND 16'hF0F0 & 16'h0FF0 → f=16'h00F0, illegal_out=0.
